mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit for the five-stage MIPS pipeline. It sits beside the E stage and consumes the rs/rt operands that E holds for mult, multu, div, divu, mthi and mtlo. It owns the HI/LO registers and exposes them for mfhi/mflo. It raises `busy` so the hazard controller can stall the D stage.

## Interface
- `MULT_CYCLES`, default 5, cycles from accepted start to HI/LO update for mult/multu.
- `DIV_CYCLES`, default 10, cycles from accepted start to HI/LO update for div/divu.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `start`  input  1  E-stage request, already qualified by ctrl; sampled on the rising edge.
- `md_op`  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved (no-op).
- `rs_val`  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- `rt_val`  input  32  forwarded rt operand (divisor / multiplier).
- `busy`  output  1  high while an operation is in flight.
- `hi`  output  32  HI register, registered.
- `lo`  output  32  LO register, registered.

## Operation
- States: IDLE and RUN.
- IDLE, `start` with op 0–3:
  - Latch the full 64-bit result into internal `res_hi`/`res_lo`.
  - Load the down-counter with MULT_CYCLES or DIV_CYCLES, set busy, go to RUN.
- IDLE, `start` with op 4/5: write `rs_val` to hi/lo at that edge; busy stays 0; stay in IDLE.
- RUN: decrement the counter each edge. At the edge where the count reaches 0, copy `res_hi`/`res_lo` to hi/lo, clear busy, return to IDLE.
- `start` while busy: ignored entirely, with no state change. ctrl must stall any md instruction in D while `busy | start`.
- mult: signed 32x32→64; hi = upper word, lo = lower word. multu: the same, unsigned.
- div: signed; lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (div or divu): run the full DIV_CYCLES with busy high, then leave hi/lo unchanged.
- div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Reserved op with `start`: no-op, no busy.
- Reset: busy=0, hi=0, lo=0, state IDLE, counter 0, internal result registers 0. Reset mid-operation discards the in-flight result; no later update occurs.

## Timing
- Accepted start at edge k (op 0–3): busy is high after edge k, through edge k+N−1. At edge k+N, hi/lo update and busy falls. N = MULT_CYCLES or DIV_CYCLES, so busy is high for exactly N cycles.
- mthi/mtlo at edge k: the new value is visible on hi/lo after edge k; zero busy cycles.
- A new start is accepted at edge k+N itself, the same edge where busy falls. The unit is back-to-back capable, with no idle gap required.
- hi/lo are registered outputs; no combinational path from inputs to outputs. busy is also registered.
- The counter width is wide enough for the maximum parameter value, at minimum clog2(DIV_CYCLES+1).

## Structure
- Shared package `md_pkg` holds:
  - `md_op` encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`;
  - the state encoding `MD_IDLE`/`MD_RUN`;
  - default cycle constants.
- ctrl and the D-stage decoder import the same encodings.
- Result computation uses synthesizable `*`, `/`, `%` on sign-handled operands.
- One natural sub-module, `md_div_core`, is combinational. It performs signed/unsigned quotient and remainder, including the divide-by-zero flag and the overflow case. All sequencing stays in `mult_div_unit`.

## Test plan
- mult: rs=0xFFFFFFFF, rt=0x00000002 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu on the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div: rs=0xFFFFFFF9 (−7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via mthi/mtlo, then div rs=5, rt=0 -> busy for 10 cycles, hi=0x11 and lo=0x22 unchanged.
- mthi rs=0x00001234 while idle -> hi=0x00001234 after one edge, busy never asserted. mtlo during busy -> ignored, lo unchanged.
- Second start during mult busy: the pulse is ignored and the original result lands at k+5. A start at edge k+5 is accepted and its result lands at k+10.
- Async reset asserted mid-cycle during div counter=4 -> busy, hi and lo go to 0 immediately. After release, no update occurs for the discarded div.

Source files
------------

// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide unit. The ctrl block and the
// D-stage decoder import the same md_op encodings.
//   - md_op encodings (3 bits; 6 and 7 are reserved no-ops)
//   - FSM state encoding for mult_div_unit
//   - default latency constants for multiply and divide
// -----------------------------------------------------------------------------
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   localparam int MD_MULT_CYCLES_DEFAULT = 5;
   localparam int MD_DIV_CYCLES_DEFAULT  = 10;

   // mult, multu, div and divu all have op[2] clear; they are the only
   // operations that occupy the unit for several cycles.
   function automatic logic md_is_arith(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/md_div_core.sv
// -----------------------------------------------------------------------------
// md_div_core
// Purely combinational 32-bit divider, signed or unsigned.
//   dividend    in  32  numerator (rs)
//   divisor     in  32  denominator (rt)
//   is_signed   in  1   1 = div (two's complement), 0 = divu
//   quotient    out 32  truncated toward zero
//   remainder   out 32  takes the sign of the dividend (signed case)
//   div_by_zero out 1   divisor is zero; quotient/remainder are meaningless
//   overflow    out 1   signed 0x80000000 / -1
// -----------------------------------------------------------------------------
module md_div_core (
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        is_signed,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero,
   output logic        overflow
);

   logic        neg_dividend;
   logic        neg_divisor;
   logic [31:0] mag_dividend;
   logic [31:0] mag_divisor;
   logic [31:0] mag_quotient;
   logic [31:0] mag_remainder;

   always_comb begin
      div_by_zero  = (divisor == 32'd0);
      overflow     = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

      neg_dividend = is_signed & dividend[31];
      neg_divisor  = is_signed & divisor[31];

      // Magnitudes as unsigned values; -0x80000000 wraps to 0x80000000,
      // which is the correct unsigned magnitude.
      mag_dividend = neg_dividend ? (32'd0 - dividend) : dividend;
      mag_divisor  = neg_divisor  ? (32'd0 - divisor)  : divisor;

      // Keep the divide well defined when the divisor is zero; the result is
      // discarded by the sequencer in that case.
      if (div_by_zero) begin
         mag_divisor = 32'd1;
      end

      mag_quotient  = mag_dividend / mag_divisor;
      mag_remainder = mag_dividend % mag_divisor;

      quotient  = (neg_dividend ^ neg_divisor) ? (32'd0 - mag_quotient) : mag_quotient;
      remainder = neg_dividend ? (32'd0 - mag_remainder) : mag_remainder;

      if (overflow) begin
         quotient  = 32'h8000_0000;
         remainder = 32'd0;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit beside the E stage. Owns HI/LO.
// The result is computed at the accepting edge and held internally; it is
// released to HI/LO after MULT_CYCLES / DIV_CYCLES, matching the stall the
// hazard controller applies while busy is high.
//   clk     in  1   clock, rising edge
//   reset   in  1   asynchronous, active-high
//   start   in  1   request from E (already qualified)
//   md_op   in  3   operation (md_pkg encodings)
//   rs_val  in  32  rs operand
//   rt_val  in  32  rt operand
//   busy    out 1   operation in flight (registered)
//   hi      out 32  HI register
//   lo      out 32  LO register
// -----------------------------------------------------------------------------
module mult_div_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e          state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               busy_reg, busy_next;
   logic [31:0]        hi_reg, hi_next;
   logic [31:0]        lo_reg, lo_next;
   logic [31:0]        res_hi_reg, res_hi_next;
   logic [31:0]        res_lo_reg, res_lo_next;

   logic [63:0]        prod_signed;
   logic [63:0]        prod_unsigned;
   logic [31:0]        div_quot;
   logic [31:0]        div_rem;
   logic               div_zero;
   logic               div_ovf;
   logic               last_cycle;
   logic               accept;
   logic [31:0]        hi_after_edge;
   logic [31:0]        lo_after_edge;
   logic [31:0]        arith_hi;
   logic [31:0]        arith_lo;

   // The low 64 bits of a product of sign-extended operands equal the
   // signed 32x32 product, so one unsigned 64-bit multiply covers mult.
   assign prod_signed   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
   assign prod_unsigned = {32'd0, rs_val} * {32'd0, rt_val};

   md_div_core u_div_core (
      .dividend    (rs_val),
      .divisor     (rt_val),
      .is_signed   (md_op == MD_DIV),
      .quotient    (div_quot),
      .remainder   (div_rem),
      .div_by_zero (div_zero),
      .overflow    (div_ovf)
   );

   // The final RUN edge retires the current result and may accept the next
   // request in the same edge, so the unit is back-to-back capable.
   assign last_cycle = (state_reg == MD_RUN) && (cnt_reg == CNT_W'(1));
   assign accept     = start && ((state_reg == MD_IDLE) || last_cycle);

   // HI/LO as they will stand after this edge if no new op touched them.
   // A divide by zero accepted on a retiring edge must preserve the value
   // that is landing, not the stale register.
   assign hi_after_edge = last_cycle ? res_hi_reg : hi_reg;
   assign lo_after_edge = last_cycle ? res_lo_reg : lo_reg;

   always_comb begin
      arith_hi = prod_signed[63:32];
      arith_lo = prod_signed[31:0];
      case (md_op)
         MD_MULTU: begin
            arith_hi = prod_unsigned[63:32];
            arith_lo = prod_unsigned[31:0];
         end
         MD_DIV, MD_DIVU: begin
            arith_hi = div_zero ? hi_after_edge : div_rem;
            arith_lo = div_zero ? lo_after_edge : div_quot;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      busy_next   = busy_reg;
      hi_next     = hi_reg;
      lo_next     = lo_reg;
      res_hi_next = res_hi_reg;
      res_lo_next = res_lo_reg;

      if (state_reg == MD_RUN) begin
         cnt_next = cnt_reg - CNT_W'(1);
         if (last_cycle) begin
            hi_next    = res_hi_reg;
            lo_next    = res_lo_reg;
            busy_next  = 1'b0;
            state_next = MD_IDLE;
         end
      end

      if (accept) begin
         if (md_is_arith(md_op)) begin
            res_hi_next = arith_hi;
            res_lo_next = arith_lo;
            cnt_next    = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy_next   = 1'b1;
            state_next  = MD_RUN;
         end else if (md_op == MD_MTHI) begin
            hi_next = rs_val;
         end else if (md_op == MD_MTLO) begin
            lo_next = rs_val;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= MD_IDLE;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         hi_reg     <= 32'd0;
         lo_reg     <= 32'd0;
         res_hi_reg <= 32'd0;
         res_lo_reg <= 32'd0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         busy_reg   <= busy_next;
         hi_reg     <= hi_next;
         lo_reg     <= lo_next;
         res_hi_reg <= res_hi_next;
         res_lo_reg <= res_lo_next;
      end
   end

   assign busy = busy_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: a vector table of arithmetic ops fed
// through a scoreboard, plus hand-written sequences for mthi/mtlo, divide by
// zero, ignored and back-to-back starts, and asynchronous reset mid-divide.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   always #5 clk = ~clk;

   mult_div_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .md_op  (md_op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      logic        busy_after;
      int          id;
   } sb_t;

   sb_t  sb[$];
   vec_t vecs[14];
   int   total = 0;
   int   bad   = 0;
   int   run_cnt = 0;
   int   seen;
   sb_t  cur;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] h, input logic [31:0] l, input int cyc,
                       input logic b_after, input int id);
      sb_t e;
      e.hi = h; e.lo = l; e.cycles = cyc; e.busy_after = b_after; e.id = id;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; md_op = op; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
      total++;
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL %s: %0d results still pending, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
      vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{MD_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
      vecs[6]  = '{MD_MULTU, 32'h80000000, 32'h00000004, 32'h00000002, 32'h00000000};
      vecs[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[8]  = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
      vecs[9]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      vecs[10] = '{MD_DIV,   32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      vecs[11] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[12] = '{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
      vecs[13] = '{MD_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};

      reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0;

      // Scoreboard monitor: counts busy cycles and retires the head entry
      // when busy drops or when the entry's cycle budget is exceeded.
      fork
         forever begin
            @(negedge clk);
            if (reset) begin
               run_cnt = 0;
            end else begin
               if (busy) run_cnt++;
               if (sb.size() > 0 && ((!busy && run_cnt > 0) || run_cnt > sb[0].cycles)) begin
                  cur  = sb.pop_front();
                  seen = busy ? run_cnt - 1 : run_cnt;
                  check($sformatf("op%0d_busy_cycles", cur.id), 32'(seen), 32'(cur.cycles));
                  check($sformatf("op%0d_hi", cur.id), hi, cur.hi);
                  check($sformatf("op%0d_lo", cur.id), lo, cur.lo);
                  check($sformatf("op%0d_busy_after", cur.id), {31'd0, busy}, {31'd0, cur.busy_after});
                  $display("txn op%0d: hi=%h lo=%h busy_cycles=%0d", cur.id, hi, lo, seen);
                  run_cnt = busy ? 1 : 0;
               end else if (!busy) begin
                  run_cnt = 0;
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven arithmetic
      for (int i = 0; i < 14; i++) begin
         push(vecs[i].hi, vecs[i].lo, (vecs[i].op[1] ? 10 : 5), 1'b0, i);
         issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
         wait_drain($sformatf("drain_op%0d", i));
      end

      // mthi / mtlo while idle: visible after one edge, no busy
      issue(MD_MTHI, 32'h00001234, 32'd0);
      check("mthi_hi", hi, 32'h00001234);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      $display("txn mthi: hi=%h busy=%0d", hi, busy);
      issue(MD_MTLO, 32'h00005678, 32'd0);
      check("mtlo_lo", lo, 32'h00005678);
      check("mtlo_hi_kept", hi, 32'h00001234);
      $display("txn mtlo: lo=%h busy=%0d", lo, busy);

      // Reserved op: no busy, no register change
      issue(3'd6, 32'hDEADBEEF, 32'h1);
      check("reserved_busy", {31'd0, busy}, 32'd0);
      check("reserved_hi", hi, 32'h00001234);
      check("reserved_lo", lo, 32'h00005678);
      $display("txn reserved: hi=%h lo=%h busy=%0d", hi, lo, busy);

      // Divide by zero keeps HI/LO; mtlo during busy is ignored
      issue(MD_MTHI, 32'h00000011, 32'd0);
      issue(MD_MTLO, 32'h00000022, 32'd0);
      push(32'h00000011, 32'h00000022, 10, 1'b0, 100);
      issue(MD_DIV, 32'h00000005, 32'h00000000);
      start = 1'b1; md_op = MD_MTLO; rs_val = 32'h00000099;
      @(negedge clk);
      start = 1'b0;
      check("mtlo_busy_lo", lo, 32'h00000022);
      check("mtlo_busy_busy", {31'd0, busy}, 32'd1);
      wait_drain("drain_divzero");

      // Ignored start during busy, then back-to-back start on the retiring edge
      push(32'h00000000, 32'h0000002A, 5, 1'b1, 101);
      push(32'hFFFFFFFE, 32'h00000001, 5, 1'b0, 102);
      @(negedge clk);
      start = 1'b1; md_op = MD_MULT; rs_val = 32'd6; rt_val = 32'd7;    // edge k
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd3;   // edge k+2, ignored
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; md_op = MD_MULTU; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF; // edge k+5
      @(negedge clk);
      start = 1'b0;
      check("b2b_first_lo", lo, 32'h0000002A);
      check("b2b_second_busy", {31'd0, busy}, 32'd1);
      wait_drain("drain_b2b");

      // Asynchronous reset mid-divide (counter = 4)
      issue(MD_MTHI, 32'h0000AAAA, 32'd0);
      issue(MD_MTLO, 32'h0000BBBB, 32'd0);
      issue(MD_DIV, 32'd100, 32'd7);                  // accepted at edge k
      repeat (6) @(negedge clk);                      // just after edge k+6
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_busy", {31'd0, busy}, 32'd0);
      check("async_reset_hi", hi, 32'd0);
      check("async_reset_lo", lo, 32'd0);
      $display("txn async_reset: hi=%h lo=%h busy=%0d", hi, lo, busy);
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      check("post_reset_hi", hi, 32'd0);
      check("post_reset_lo", lo, 32'd0);
      check("post_reset_busy", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
